// File: rtl/serial_comparator_param_if.sv
// ---------------------------------------------------------------------------
// serial_comparator_param_if
//
// Bundles the digit stream and result flags of serial_comparator_param.
//
// Handshake: a digit pair (a, b) is consumed on a rising clk edge exactly
// when valid=1, start=0 and the comparator is busy (RUN). There is no
// back-pressure: while busy the comparator accepts every valid digit, and
// outside RUN (or in a start cycle) valid is ignored. start aborts any
// comparison in flight and latches msb_first / is_signed.
//
// Parameter
//   DIGIT_W   bits per digit of each operand
// Signals
//   start, msb_first, is_signed, valid, a, b   : master -> comparator
//   L, E, G, res_valid, busy                   : comparator -> master
// ---------------------------------------------------------------------------
interface serial_comparator_param_if #(
    parameter int DIGIT_W = 1
);
    logic               start;
    logic               msb_first;
    logic               is_signed;
    logic               valid;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               L;
    logic               E;
    logic               G;
    logic               res_valid;
    logic               busy;

    modport master (
        output start, msb_first, is_signed, valid, a, b,
        input  L, E, G, res_valid, busy
    );

    modport slave (
        input  start, msb_first, is_signed, valid, a, b,
        output L, E, G, res_valid, busy
    );
endinterface

// File: rtl/serial_comparator_param.sv
// ---------------------------------------------------------------------------
// serial_comparator_param
//
// Digit-serial magnitude comparator. Two LEN-bit operands arrive DIGIT_W
// bits per accepted cycle, MSB-first or LSB-first, and the block reports
// exactly one of L (A<B), E (A==B), G (A>B). res_valid marks the final
// result, which is held in DONE until the next start or rst.
//
// Optional feature: define SIGNED_CMP_EN to enable two's-complement
// comparison selected by is_signed at start. Without it is_signed is
// ignored and all comparisons are unsigned.
//
// Parameters
//   DIGIT_W    bits per digit (>=1)
//   LEN        operand width, multiple of DIGIT_W
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset, overrides start
//   bus        serial_comparator_param_if.slave (digits, mode, results)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module serial_comparator_param #(
    parameter int DIGIT_W = 1,
    parameter int LEN     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    serial_comparator_param_if.slave         bus,
    output logic [1:0]                       state_dbg
);
    localparam int NDIG = LEN / DIGIT_W;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          l_q, l_n;
    logic          e_q, e_n;
    logic          g_q, g_n;
    logic          msb_q, msb_n;

    logic [DIGIT_W-1:0] da, db;
    logic               dlt, dgt;

`ifdef SIGNED_CMP_EN
    logic sgn_q, sgn_n;
    logic sign_digit;
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
`endif

    // Digit pair as compared; in signed mode the sign digit has its top
    // bit flipped, which maps two's-complement order onto unsigned order.
    always_comb begin
        da = bus.a;
        db = bus.b;
`ifdef SIGNED_CMP_EN
        sign_digit = msb_q ? (cnt_q == '0) : (cnt_q == LAST);
        if (sgn_q && sign_digit) begin
            da[DIGIT_W-1] = ~bus.a[DIGIT_W-1];
            db[DIGIT_W-1] = ~bus.b[DIGIT_W-1];
        end
`endif
        dlt = (da < db);
        dgt = (da > db);
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        l_n     = l_q;
        e_n     = e_q;
        g_n     = g_q;
        msb_n   = msb_q;
`ifdef SIGNED_CMP_EN
        sgn_n   = sgn_q;
`endif
        if (bus.start) begin
            state_n = RUN;
            cnt_n   = '0;
            l_n     = 1'b0;
            e_n     = 1'b1;
            g_n     = 1'b0;
            msb_n   = bus.msb_first;
`ifdef SIGNED_CMP_EN
            sgn_n   = bus.is_signed;
`endif
        end else if (state_q == RUN && bus.valid) begin
            // MSB-first: only the first differing digit decides (e_q still
            // set means no decision yet). LSB-first: each differing digit
            // overrides, so the most significant difference wins.
            if ((dlt || dgt) && (!msb_q || e_q)) begin
                l_n = dlt;
                e_n = 1'b0;
                g_n = dgt;
            end
            if (cnt_q == LAST) begin
                state_n = DONE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= 1'b0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
            msb_q   <= 1'b1;
`ifdef SIGNED_CMP_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            l_q     <= l_n;
            e_q     <= e_n;
            g_q     <= g_n;
            msb_q   <= msb_n;
`ifdef SIGNED_CMP_EN
            sgn_q   <= sgn_n;
`endif
        end
    end

    assign bus.L         = l_q;
    assign bus.E         = e_q;
    assign bus.G         = g_q;
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_serial_comparator_param.sv
// ---------------------------------------------------------------------------
// tb_serial_comparator_param
//
// Directed bench for serial_comparator_param with DIGIT_W=2, LEN=8.
// Expected {res_valid, busy, L, E, G} tuples come from an operand-level
// model: after n accepted digits, MSB-first compares the top 2n bits and
// LSB-first compares the low 2n bits; signed mode flips bit 7 of both
// operands first.
// ---------------------------------------------------------------------------
module tb_serial_comparator_param;
    localparam int DW  = 2;
    localparam int LEN = 8;
    localparam int ND  = LEN / DW;
`ifdef SIGNED_CMP_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    serial_comparator_param_if #(.DIGIT_W(DW)) ifc ();

    serial_comparator_param #(.DIGIT_W(DW), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [4:0] exp_q[$];

    localparam logic [4:0] RESET_T = 5'b00010;

    function automatic logic [4:0] model(input logic [7:0] av, input logic [7:0] bv,
                                         input logic msb, input logic sgn, input int n);
        logic [7:0] xa, xb;
        logic [15:0] pa, pb;
        logic lt, gt;
        xa = av ^ ((sgn && SGN_EN) ? 8'h80 : 8'h00);
        xb = bv ^ ((sgn && SGN_EN) ? 8'h80 : 8'h00);
        if (n == 0) begin
            pa = 16'd0;
            pb = 16'd0;
        end else if (msb) begin
            pa = {8'd0, xa} >> (LEN - DW * n);
            pb = {8'd0, xb} >> (LEN - DW * n);
        end else begin
            pa = {8'd0, xa} & ((16'd1 << (DW * n)) - 16'd1);
            pb = {8'd0, xb} & ((16'd1 << (DW * n)) - 16'd1);
        end
        lt = (pa < pb);
        gt = (pa > pb);
        return {(n == ND), (n != ND), lt, !(lt || gt), gt};
    endfunction

    function automatic logic [4:0] observed();
        return {ifc.res_valid, ifc.busy, ifc.L, ifc.E, ifc.G};
    endfunction

    // Clock one edge, then pop the expected tuple and compare.
    task automatic step_check(input string tag);
        logic [4:0] exp_v;
        logic [4:0] obs;
        @(posedge clk);
        #1;
        obs = observed();
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            compared++;
            assert (obs === exp_v) else begin
                mismatched++;
                $error("FAIL %s: observed {rv,busy,L,E,G}=%b expected %b", tag, obs, exp_v);
            end
        end
    endtask

    task automatic do_start(input logic msb, input logic sgn);
        ifc.start     = 1'b1;
        ifc.msb_first = msb;
        ifc.is_signed = sgn;
        ifc.valid     = 1'b1;      // must be ignored in the start cycle
        ifc.a         = 2'b11;
        ifc.b         = 2'b00;
        exp_q.push_back(5'b01010);
        step_check("start");
        ifc.start = 1'b0;
    endtask

    // Feed digits first..first+count-1 of A/B; gap inserts a valid=0 cycle
    // before each digit, during which outputs must not move.
    task automatic feed(input logic [7:0] av, input logic [7:0] bv, input logic msb,
                        input logic sgn, input int first, input int count,
                        input logic gap, input string tag);
        int idx;
        for (int k = first; k < first + count; k++) begin
            if (gap) begin
                ifc.valid = 1'b0;
                ifc.a     = 2'b11;
                ifc.b     = 2'b00;
                exp_q.push_back(model(av, bv, msb, sgn, k));
                step_check({tag, "_gap"});
            end
            idx       = msb ? (ND - 1 - k) : k;
            ifc.valid = 1'b1;
            ifc.a     = av[idx*DW +: DW];
            ifc.b     = bv[idx*DW +: DW];
            exp_q.push_back(model(av, bv, msb, sgn, k + 1));
            step_check(tag);
        end
        ifc.valid = 1'b0;
    endtask

    task automatic final_check(input string tag, input logic [4:0] exp_v);
        compared++;
        assert (observed() === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, observed(), exp_v);
        end
    endtask

    initial begin
        ifc.start = 1'b0; ifc.msb_first = 1'b1; ifc.is_signed = 1'b0;
        ifc.valid = 1'b0; ifc.a = '0; ifc.b = '0;

        // Reset held two cycles, with start high to show rst dominates.
        rst = 1'b1;
        ifc.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ifc.start = 1'b0;
        final_check("reset", RESET_T);
        compared++;
        assert (state_dbg === 2'd0) else begin
            mismatched++;
            $error("FAIL reset_state: observed %0d expected 0", state_dbg);
        end
        rst = 1'b0;

        // valid in IDLE is ignored.
        ifc.valid = 1'b1; ifc.a = 2'b11; ifc.b = 2'b00;
        exp_q.push_back(RESET_T);
        step_check("idle_valid");
        ifc.valid = 1'b0;

        // MSB-first unsigned B4 vs B1.
        do_start(1'b1, 1'b0);
        feed(8'hB4, 8'hB1, 1'b1, 1'b0, 0, ND, 1'b0, "msb_b4_b1");
        final_check("msb_b4_b1_final", 5'b10001);

        // valid in DONE is ignored; result held.
        ifc.valid = 1'b1; ifc.a = 2'b00; ifc.b = 2'b11;
        exp_q.push_back(5'b10001);
        step_check("done_hold");
        ifc.valid = 1'b0;

        // LSB-first unsigned, same operands.
        do_start(1'b0, 1'b0);
        feed(8'hB4, 8'hB1, 1'b0, 1'b0, 0, ND, 1'b0, "lsb_b4_b1");
        final_check("lsb_b4_b1_final", 5'b10001);

        // Equal operands with valid gaps.
        do_start(1'b1, 1'b0);
        feed(8'h5A, 8'h5A, 1'b1, 1'b0, 0, ND, 1'b1, "eq_gaps");
        final_check("eq_gaps_final", 5'b10010);

        // Signed 0x80 vs 0x7F, both orders, then unsigned.
        do_start(1'b1, 1'b1);
        feed(8'h80, 8'h7F, 1'b1, 1'b1, 0, ND, 1'b0, "sgn_msb");
        final_check("sgn_msb_final", SGN_EN ? 5'b10100 : 5'b10001);
        do_start(1'b0, 1'b1);
        feed(8'h80, 8'h7F, 1'b0, 1'b1, 0, ND, 1'b0, "sgn_lsb");
        final_check("sgn_lsb_final", SGN_EN ? 5'b10100 : 5'b10001);
        do_start(1'b1, 1'b0);
        feed(8'h80, 8'h7F, 1'b1, 1'b0, 0, ND, 1'b0, "uns_80_7f");
        final_check("uns_80_7f_final", 5'b10001);

        // Random operands, random order and mode.
        for (int t = 0; t < 6; t++) begin
            logic [7:0] ra, rb;
            logic rm, rs;
            ra = 8'($urandom_range(0, 255));
            rb = (t == 0) ? ra : 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            do_start(rm, rs);
            feed(ra, rb, rm, rs, 0, ND, 1'($urandom_range(0, 1)), "rand");
        end

        // Abort mid-RUN then restart with equal operands.
        do_start(1'b1, 1'b0);
        feed(8'h00, 8'hFF, 1'b1, 1'b0, 0, 2, 1'b0, "abort_pre");
        do_start(1'b1, 1'b0);
        feed(8'h33, 8'h33, 1'b1, 1'b0, 0, ND, 1'b0, "restart");
        final_check("restart_final", 5'b10010);

        // rst mid-RUN, with start also high.
        do_start(1'b0, 1'b0);
        feed(8'h00, 8'hFF, 1'b0, 1'b0, 0, 2, 1'b0, "rst_pre");
        rst = 1'b1;
        ifc.start = 1'b1;
        ifc.valid = 1'b1;
        exp_q.push_back(RESET_T);
        step_check("rst_mid_run");
        rst = 1'b0;
        ifc.start = 1'b0;
        ifc.valid = 1'b0;
        exp_q.push_back(RESET_T);
        step_check("after_rst");

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/serial_comparator_param.md
# serial_comparator_param

Parametrised digit-serial magnitude comparator: two operands of `LEN` bits arrive `DIGIT_W` bits per accepted cycle, and the block reports less / equal / greater once all digits are in. It is the multi-bit, mode-selectable successor of the single-bit comparator FSM. It adds digit-order selection (MSB-first or LSB-first), an optional signed mode, a valid handshake and an explicit result-valid flag.

## Interface
- `DIGIT_W`, default 1: bits of each operand presented per accepted digit; ≥1.
- `LEN`, default 8: total operand width in bits; `LEN % DIGIT_W == 0`, `LEN ≥ DIGIT_W`; `NDIG = LEN/DIGIT_W`.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new comparison; latches mode inputs.
- `msb_first`  in  1  digit order, sampled on `start`: 1 = most-significant digit first; 0 = least-significant first.
- `is_signed`  in  1  sampled on `start`: 1 = two's-complement compare. Honoured only with `SIGNED_CMP_EN`.
- `valid`  in  1  current `a`/`b` digit is valid.
- `a`  in  DIGIT_W  digit of operand A.
- `b`  in  DIGIT_W  digit of operand B.
- `L`  out  1  A < B.
- `E`  out  1  A == B.
- `G`  out  1  A > B.
- `res_valid`  out  1  L/E/G hold the final result.
- `busy`  out  1  comparison in progress (state RUN).

## Operation
- States:
  - IDLE (after reset).
  - RUN: digits being accepted.
  - DONE: result held.
- Transitions:
  - IDLE/DONE/RUN + `start` → RUN. Clears the digit counter, sets L=0 E=1 G=0 and res_valid=0, and latches `msb_first`/`is_signed`. `start` always wins, including an abort mid-RUN.
  - RUN + `valid` (no `start`) accepts one digit and increments the counter. When the accepted digit is digit `NDIG-1`, the next state is DONE.
  - DONE holds L/E/G until `start` or `rst`.
  - `valid` is ignored in IDLE, in DONE, and in the cycle `start` is high. A RUN cycle with `valid`=0 changes nothing.
- Digit decision: each accepted digit is compared unsigned, giving lt/gt/eq.
  - MSB-first: the first non-equal digit sets L/G/E. Later digits are ignored once a decision has been made (sticky).
  - LSB-first: every non-equal digit overwrites L/G/E. An equal digit leaves the previous decision. The final answer is therefore decided by the most significant differing digit.
- Signed mode: in the digit holding operand bit `LEN-1`, invert bit `DIGIT_W-1` of both `a` and `b` before comparing.
  - MSB-first: this is the digit with counter 0.
  - LSB-first: this is the digit with counter `NDIG-1`.
- Exactly one of L/E/G is 1 at all times.

## Timing
- Reset values: state IDLE, L=0, E=1, G=0, res_valid=0, busy=0, counter=0.
- `busy`=1 from the cycle after `start` until the cycle after the final digit is accepted.
- L/E/G update on the same edge that accepts a digit, so intermediate values are visible while in RUN.
- Latency: with `valid` held high, `res_valid` rises `NDIG` cycles after the `start` cycle. It rises in the cycle following the edge that accepts the last digit.
- `rst` overrides everything, including `start`, and acts in any state, mid-comparison included.

## Configuration
- `SIGNED_CMP_EN` defined: the signed-mode logic is present and `is_signed` is sampled as described.
- `SIGNED_CMP_EN` not defined: the port `is_signed` still exists but is ignored. All comparisons are unsigned and the sign-bit inversion logic is absent.

## Test plan
All scenarios use DIGIT_W=2, LEN=8 and `valid` held high unless noted.
- Reset: assert `rst` 2 cycles → L=0 E=1 G=0, res_valid=0, busy=0.
- MSB-first unsigned, A=0xB4, B=0xB1.
  - Digits: a = 10,11,01,00; b = 10,11,00,01.
  - Required: G=1 from the 3rd accepted digit onward; res_valid=1 after the 4th digit, with L=0 E=0 G=1.
- LSB-first unsigned, same operands.
  - Digits: a = 00,01,11,10; b = 01,00,11,10.
  - Required: after digit 1, L=1; after digit 2, G=1; final G=1, res_valid=1.
- Equal with gaps: A=B=0x5A, MSB-first, `valid` low every other cycle. Required: E=1 throughout, res_valid after 4 accepted digits (8 cycles).
- Signed: A=0x80, B=0x7F, MSB-first, `is_signed`=1.
  - With `SIGNED_CMP_EN`: final L=1.
  - Without `SIGNED_CMP_EN`: final G=1.
  - With `is_signed`=0 (either build): G=1.
- Abort/restart: start, accept 2 digits of A=0x00 / B=0xFF, reassert `start`, then feed A=B=0x33. Required: res_valid=0 until 4 new digits are accepted, then E=1. Also: `rst` pulsed mid-RUN returns all outputs to reset values.
